mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, maximum cycles a granted access waits for mem_done before abort.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 f_address  in  64  fetch-unit byte address.
REQ-006 f_datasize  in  2  fetch size: 0 byte, 1 wyde, 2 tetra, 3 octa.
REQ-007 f_read  in  1  fetch read request, level, held until f_done.
REQ-008 f_done  out  1  one-cycle completion pulse to fetch unit.
REQ-009 e_address  in  64  exec-unit byte address.
REQ-010 e_datasize  in  2  exec size, same encoding.
REQ-011 e_read  in  1  exec read request, level, held until e_done.
REQ-012 e_write  in  1  exec write request, level, held until e_done.
REQ-013 e_writedata  in  64  exec store data.
REQ-014 e_done  out  1  one-cycle completion pulse to exec unit.
REQ-015 rdata  out  64  read data, valid while f_done or e_done is high.
REQ-016 err  out  1  timeout flag, valid while f_done or e_done is high.
REQ-017 mem_address, mem_datasize, mem_read, mem_write, mem_writedata  out  64/2/1/1/64  shared memory port.
REQ-018 mem_readdata  in  64; mem_done  in  1  memory response.

Function
REQ-019 States: IDLE, BUSY, RESP; encoding internal.
REQ-020 IDLE: no request -> stay IDLE; any request -> BUSY next cycle, granted requester's address, size, read/write and writedata captured into registers.
REQ-021 Only one requester active -> it is granted; both active -> the requester not granted last wins (round-robin); after reset the fetch unit is treated as last granted, so exec wins the first tie.
REQ-022 e_read and e_write both high -> treated as write.
REQ-023 BUSY: mem_* driven solely from captured registers; mem_read or mem_write (exactly one) held high; requester inputs ignored.
REQ-024 Outside BUSY: mem_read = mem_write = 0; mem_address, mem_datasize, mem_writedata hold last captured values.
REQ-025 BUSY with mem_done=1 -> capture mem_readdata into rdata, err=0, go RESP.
REQ-026 BUSY: 32-bit wait counter cleared on entry, incremented each cycle without mem_done; reaching TIMEOUT_CYCLES-1 without mem_done -> rdata=0, err=1, go RESP.
REQ-027 mem_done on the same cycle the counter expires -> normal completion, err=0.
REQ-028 RESP: exactly one of f_done/e_done high for one cycle (the granted requester); next state IDLE unconditionally, requests ignored in RESP.
REQ-029 Latency: grant-cycle request to first mem_read/mem_write = 1 cycle; mem_done to done pulse = 1 cycle; minimum gap between back-to-back grants = 1 IDLE cycle.
REQ-030 rdata and err hold their values until the next RESP.
REQ-031 mem_done outside BUSY is ignored.

Reset
REQ-032 Reset has priority over all transitions; asserted mid-access -> IDLE next cycle, access abandoned, no done pulse.
REQ-033 Reset values: state IDLE, f_done=e_done=0, mem_read=mem_write=0, mem_address=0, mem_datasize=0, mem_writedata=0, rdata=0, err=0, counter 0, last-granted=fetch.

Structure
REQ-034 The arbiter state enum and the datasize encoding constants (BYTE, WYDE, TETRA, OCTA) belong in the shared mmix_defs package.
REQ-035 One sub-module: mem_timeout_counter (clear, enable, expire output); all other logic flat in mem_arbiter.

Verification
REQ-036 Fetch only: f_read, f_address=0x8000_0000_0000_0000, size 2; memory returns 0x0000_0000_F000_0000 after 3 cycles -> single f_done, rdata=0x0000_0000_F000_0000, err=0.
REQ-037 Tie after reset: f_read and e_write (addr 0x100, data 0xDEAD_BEEF) same cycle -> exec write first, mem_writedata=0xDEAD_BEEF; fetch granted after RESP+IDLE.
REQ-038 Round-robin: both requesters held continuously for 4 accesses -> grant order E,F,E,F, each done pulse exactly one cycle.
REQ-039 Timeout: TIMEOUT_CYCLES=8, e_read, mem_done never asserted -> e_done with err=1, rdata=0, 8 cycles after BUSY entry; next access completes normally with err=0.
REQ-040 Reset mid-access: assert reset 2 cycles into BUSY -> next cycle all outputs at reset values, no done pulse, later access works.
REQ-041 e_read and e_write both high -> mem_write=1, mem_read=0 throughout BUSY.

Source files
------------

// File: rtl/mmix_defs_pkg.sv
// mmix_defs: shared arbiter state enum and memory access size encodings
package mmix_defs;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  localparam logic [1:0] BYTE  = 2'd0;
  localparam logic [1:0] WYDE  = 2'd1;
  localparam logic [1:0] TETRA = 2'd2;
  localparam logic [1:0] OCTA  = 2'd3;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: 32-bit wait counter (clear wins over enable); expire high once count reaches LIMIT-1
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [31:0] count_q, count_d;
  always_comb count_d = clear ? 32'd0 : enable ? count_q + 32'd1 : count_q;
  always_ff @(posedge clk) count_q <= reset ? 32'd0 : count_d;
  assign expire = count_q == 32'(LIMIT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of fetch (f_*) and exec (e_*) units onto one memory port (mem_*), with done pulses, rdata/err response and timeout abort
module mem_arbiter
  import mmix_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] f_address,
  input  logic [1:0]  f_datasize,
  input  logic        f_read,
  output logic        f_done,
  input  logic [63:0] e_address,
  input  logic [1:0]  e_datasize,
  input  logic        e_read,
  input  logic        e_write,
  input  logic [63:0] e_writedata,
  output logic        e_done,
  output logic [63:0] rdata,
  output logic        err,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  input  logic [63:0] mem_readdata,
  input  logic        mem_done
);
  arb_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d, last_e_q, last_e_d, err_q, err_d;
  logic        e_req, pick_e, busy, expire;
  assign e_req  = e_read | e_write;
  assign pick_e = e_req & (~f_read | ~last_e_q);
  assign busy   = state_q == BUSY;
  mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy),
    .enable (busy & ~mem_done),
    .expire (expire)
  );
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    last_e_d = last_e_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (f_read | e_req) begin
        state_d  = BUSY;
        last_e_d = pick_e;
        addr_d   = pick_e ? e_address : f_address;
        size_d   = pick_e ? e_datasize : f_datasize;
        wdata_d  = pick_e ? e_writedata : wdata_q;
        wr_d     = pick_e & e_write;
      end
      BUSY: if (mem_done | expire) begin
        state_d = RESP;
        rdata_d = mem_done ? mem_readdata : 64'd0;
        err_d   = ~mem_done;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      last_e_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      last_e_q <= last_e_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
  assign f_done        = state_q == RESP && !last_e_q;
  assign e_done        = state_q == RESP && last_e_q;
  assign mem_read      = busy & ~wr_q;
  assign mem_write     = busy & wr_q;
  assign mem_address   = addr_q;
  assign mem_datasize  = size_q;
  assign mem_writedata = wdata_q;
  assign rdata         = rdata_q;
  assign err           = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with an 8-cycle timeout
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic [63:0] f_address = '0, e_address = '0, e_writedata = '0, mem_readdata = '0;
  logic [1:0]  f_datasize = '0, e_datasize = '0;
  logic        f_read = 1'b0, e_read = 1'b0, e_write = 1'b0, mem_done = 1'b0;
  logic        f_done, e_done, err, mem_read, mem_write;
  logic [63:0] rdata, mem_address, mem_writedata;
  logic [1:0]  mem_datasize;
  int checks = 0, errors = 0;
  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .f_address(f_address), .f_datasize(f_datasize), .f_read(f_read), .f_done(f_done),
    .e_address(e_address), .e_datasize(e_datasize), .e_read(e_read), .e_write(e_write),
    .e_writedata(e_writedata), .e_done(e_done), .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_datasize(mem_datasize), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_done(mem_done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1; f_read = 1'b1; e_write = 1'b1; mem_done = 1'b1;
    e_writedata = 64'h1234; e_address = 64'h55; mem_readdata = 64'hABCD;
    tick; tick;
    checks++;
    if ({f_done, e_done, mem_read, mem_write, err} !== 5'b0 || mem_address !== 64'd0 ||
        mem_datasize !== 2'd0 || mem_writedata !== 64'd0 || rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: done=%b%b rw=%b%b err=%b addr=%h size=%0d wd=%h rdata=%h, required all zero",
               f_done, e_done, mem_read, mem_write, err, mem_address, mem_datasize, mem_writedata, rdata);
    end
    reset = 1'b0; f_read = 1'b0; e_write = 1'b0;
    tick;
    checks++;
    if ({f_done, e_done, mem_read, mem_write} !== 4'b0 || rdata !== 64'd0) begin
      errors++;
      $display("FAIL idle_mem_done_ignored: done=%b%b rw=%b%b rdata=%h, required 0000 rdata 0",
               f_done, e_done, mem_read, mem_write, rdata);
    end
    mem_done = 1'b0;
  endtask
  task automatic test_fetch_only;
    f_read = 1'b1; f_address = 64'h8000_0000_0000_0000; f_datasize = 2'd2;
    tick;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 64'h8000_0000_0000_0000 || mem_datasize !== 2'd2) begin
      errors++;
      $display("FAIL fetch_busy: rw=%b%b addr=%h size=%0d, required 10 8000000000000000 2",
               mem_read, mem_write, mem_address, mem_datasize);
    end
    tick; tick;
    checks++;
    if (f_done !== 1'b0 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait: f_done=%b mem_read=%b, required 0 1", f_done, mem_read);
    end
    mem_done = 1'b1; mem_readdata = 64'h0000_0000_F000_0000;
    tick;
    mem_done = 1'b0; f_read = 1'b0;
    checks++;
    if (f_done !== 1'b1 || e_done !== 1'b0 || rdata !== 64'h0000_0000_F000_0000 || err !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: f_done=%b e_done=%b rdata=%h err=%b mem_read=%b, required 1 0 00000000f0000000 0 0",
               f_done, e_done, rdata, err, mem_read);
    end
    tick;
    checks++;
    if (f_done !== 1'b0 || rdata !== 64'h0000_0000_F000_0000 || mem_address !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL fetch_after: f_done=%b rdata=%h addr=%h, required 0 00000000f0000000 8000000000000000",
               f_done, rdata, mem_address);
    end
  endtask
  task automatic test_tie_after_reset;
    reset = 1'b1; tick; reset = 1'b0;
    f_read = 1'b1; f_address = 64'h200; f_datasize = 2'd3;
    e_write = 1'b1; e_address = 64'h100; e_datasize = 2'd1; e_writedata = 64'hDEAD_BEEF;
    tick;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 64'h100 || mem_writedata !== 64'hDEAD_BEEF || mem_datasize !== 2'd1) begin
      errors++;
      $display("FAIL tie_exec_first: rw=%b%b addr=%h wd=%h size=%0d, required 01 100 deadbeef 1",
               mem_read, mem_write, mem_address, mem_writedata, mem_datasize);
    end
    mem_done = 1'b1; mem_readdata = 64'h77;
    tick;
    mem_done = 1'b0; e_write = 1'b0;
    checks++;
    if (e_done !== 1'b1 || f_done !== 1'b0) begin
      errors++;
      $display("FAIL tie_exec_done: e_done=%b f_done=%b, required 1 0", e_done, f_done);
    end
    tick;
    checks++;
    if ({f_done, e_done, mem_read, mem_write} !== 4'b0 || mem_writedata !== 64'hDEAD_BEEF || mem_address !== 64'h100) begin
      errors++;
      $display("FAIL tie_idle_gap: done=%b%b rw=%b%b wd=%h addr=%h, required 0000 deadbeef 100",
               f_done, e_done, mem_read, mem_write, mem_writedata, mem_address);
    end
    tick;
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 64'h200 || mem_datasize !== 2'd3) begin
      errors++;
      $display("FAIL tie_fetch_second: rw=%b%b addr=%h size=%0d, required 10 200 3",
               mem_read, mem_write, mem_address, mem_datasize);
    end
    mem_done = 1'b1; mem_readdata = 64'h99;
    tick;
    mem_done = 1'b0; f_read = 1'b0;
    checks++;
    if (f_done !== 1'b1 || e_done !== 1'b0 || rdata !== 64'h99) begin
      errors++;
      $display("FAIL tie_fetch_done: f_done=%b e_done=%b rdata=%h, required 1 0 99", f_done, e_done, rdata);
    end
    tick;
  endtask
  task automatic test_round_robin;
    f_read = 1'b1; f_address = 64'hF0;
    e_write = 1'b1; e_address = 64'hE0; e_writedata = 64'h5A5A;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (mem_write !== (i % 2 == 0) || mem_read !== (i % 2 == 1) || mem_address !== ((i % 2 == 0) ? 64'hE0 : 64'hF0)) begin
        errors++;
        $display("FAIL rr_grant_%0d: rw=%b%b addr=%h, required exec=%0d", i, mem_read, mem_write, mem_address, i % 2 == 0);
      end
      mem_done = 1'b1; mem_readdata = 64'(i + 16);
      tick;
      mem_done = 1'b0;
      checks++;
      if (e_done !== (i % 2 == 0) || f_done !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL rr_done_%0d: e_done=%b f_done=%b, required exec=%0d", i, e_done, f_done, i % 2 == 0);
      end
      tick;
      checks++;
      if (e_done !== 1'b0 || f_done !== 1'b0) begin
        errors++;
        $display("FAIL rr_pulse_%0d: e_done=%b f_done=%b, required 0 0", i, e_done, f_done);
      end
    end
    f_read = 1'b0; e_write = 1'b0;
    tick; tick;
  endtask
  task automatic test_timeout;
    e_read = 1'b1; e_address = 64'h300; mem_readdata = 64'hBAD0;
    tick;
    for (int i = 1; i < 8; i++) begin
      tick;
      checks++;
      if (e_done !== 1'b0 || mem_read !== 1'b1) begin
        errors++;
        $display("FAIL timeout_wait_%0d: e_done=%b mem_read=%b, required 0 1", i, e_done, mem_read);
      end
    end
    tick;
    e_read = 1'b0;
    checks++;
    if (e_done !== 1'b1 || err !== 1'b1 || rdata !== 64'd0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: e_done=%b err=%b rdata=%h mem_read=%b, required 1 1 0 0", e_done, err, rdata, mem_read);
    end
    tick;
    checks++;
    if (err !== 1'b1 || e_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_hold: err=%b e_done=%b, required 1 0", err, e_done);
    end
    f_read = 1'b1; f_address = 64'h400;
    tick;
    mem_done = 1'b1; mem_readdata = 64'hC0FFEE;
    tick;
    mem_done = 1'b0; f_read = 1'b0;
    checks++;
    if (f_done !== 1'b1 || err !== 1'b0 || rdata !== 64'hC0FFEE) begin
      errors++;
      $display("FAIL timeout_recover: f_done=%b err=%b rdata=%h, required 1 0 c0ffee", f_done, err, rdata);
    end
    tick;
  endtask
  task automatic test_done_at_expiry;
    e_read = 1'b1; e_address = 64'h500;
    tick;
    for (int i = 1; i < 8; i++) tick;
    mem_done = 1'b1; mem_readdata = 64'h1357;
    tick;
    mem_done = 1'b0; e_read = 1'b0;
    checks++;
    if (e_done !== 1'b1 || err !== 1'b0 || rdata !== 64'h1357) begin
      errors++;
      $display("FAIL expiry_done_wins: e_done=%b err=%b rdata=%h, required 1 0 1357", e_done, err, rdata);
    end
    tick;
  endtask
  task automatic test_read_write_both;
    e_read = 1'b1; e_write = 1'b1; e_address = 64'h600; e_writedata = 64'h2468;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_writedata !== 64'h2468) begin
        errors++;
        $display("FAIL rw_both_%0d: rw=%b%b wd=%h, required 01 2468", i, mem_read, mem_write, mem_writedata);
      end
    end
    mem_done = 1'b1;
    tick;
    mem_done = 1'b0; e_read = 1'b0; e_write = 1'b0;
    checks++;
    if (e_done !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL rw_both_done: e_done=%b mem_write=%b, required 1 0", e_done, mem_write);
    end
    tick;
  endtask
  task automatic test_reset_mid_access;
    e_write = 1'b1; e_address = 64'h700; e_datasize = 2'd3; e_writedata = 64'h9999;
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0; e_write = 1'b0;
    checks++;
    if ({f_done, e_done, mem_read, mem_write, err} !== 5'b0 || mem_address !== 64'd0 ||
        mem_datasize !== 2'd0 || mem_writedata !== 64'd0 || rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: done=%b%b rw=%b%b err=%b addr=%h size=%0d wd=%h rdata=%h, required all zero",
               f_done, e_done, mem_read, mem_write, err, mem_address, mem_datasize, mem_writedata, rdata);
    end
    tick;
    checks++;
    if (e_done !== 1'b0 || f_done !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: e_done=%b f_done=%b mem_write=%b, required 0 0 0", e_done, f_done, mem_write);
    end
    f_read = 1'b1; f_address = 64'h800; f_datasize = 2'd0;
    tick;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 64'h800) begin
      errors++;
      $display("FAIL reset_later_grant: mem_read=%b addr=%h, required 1 800", mem_read, mem_address);
    end
    mem_done = 1'b1; mem_readdata = 64'h4242;
    tick;
    mem_done = 1'b0; f_read = 1'b0;
    checks++;
    if (f_done !== 1'b1 || rdata !== 64'h4242 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_later_done: f_done=%b rdata=%h err=%b, required 1 4242 0", f_done, rdata, err);
    end
    tick;
  endtask
  initial begin
    test_reset;
    test_fetch_only;
    test_tie_after_reset;
    test_round_robin;
    test_timeout;
    test_done_at_expiry;
    test_read_write_both;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
